descriptor_bin_serializer: RTL and testbench
============================================

Name: descriptor_bin_serializer

Overview:
- Consumer side of the 8-bin orientation histogram stage.
- Captures the eight 13-bit bin values of one subregion on a valid strobe into a two-bank ping-pong buffer.
- Streams them out one word per valid/ready handshake, tagged with bin and subregion indices, to build the 128-element SIFT descriptor stream (16 subregions x 8 bins).
- Marks the last word of each descriptor.

Parameters:
- BIN_W, 13, width of each bin value and of odata.
- SUBREGIONS, 16, subregions per descriptor; osub_idx wraps at SUBREGIONS-1.
- CLAMP_MAX, 13'd4095, saturation ceiling; used only when DESC_CLAMP_EN is defined.

Ports:
- iclk  input  1  clock; all logic on rising edge.
- ireset  input  1  synchronous, active-high reset.
- ibin_value0..ibin_value7  input  BIN_W each  histogram bins 0..7 (0-45 .. 315-360 deg) of one subregion.
- ibin_valid  input  1  bins valid this cycle.
- obin_ready  output  1  a write bank is free; a capture occurs on ibin_valid && obin_ready.
- odata  output  BIN_W  current descriptor word.
- ovalid  output  1  odata valid.
- iready  input  1  downstream accepts; a transfer occurs on ovalid && iready.
- obin_idx  output  3  bin index of odata (0..7).
- osub_idx  output  4  subregion index of odata (0..SUBREGIONS-1).
- olast  output  1  high with the word where osub_idx==SUBREGIONS-1 and obin_idx==7.
- oerr_drop  output  1  sticky: ibin_valid seen while obin_ready low.

Behaviour:
- Reset values, applied on any ireset cycle including mid-stream:
  - both banks EMPTY; wbank=0, rbank=0, bin counter=0, sub counter=0.
  - ovalid=0, odata=0, obin_idx=0, osub_idx=0, olast=0, oerr_drop=0.
  - obin_ready=1 from the first cycle after reset.
  - Any partial descriptor is discarded; the next capture is subregion 0.
- Bank state: each bank is EMPTY or FULL (1-bit register).
  - obin_ready = (state[wbank]==EMPTY), decoded from registers only, with no path from iready.
- Capture:
  - On ibin_valid && obin_ready, all 8 values are latched into bank[wbank], state[wbank] becomes FULL and wbank toggles.
  - Inputs are sampled only on that edge.
- Read FSM states:
  - IDLE: ovalid=0. Go to SEND when state[rbank]==FULL.
  - SEND: ovalid=1 and odata=bank[rbank][bin]. On transfer, bin increments.
  - On transfer with bin==7: bin returns to 0, state[rbank] becomes EMPTY, rbank toggles, and sub increments (wrapping SUBREGIONS-1 -> 0). Stay in SEND if the other bank is FULL, otherwise go to IDLE.
- Latency: a capture at edge N gives ovalid=1 with bin 0 from cycle N+1 when the read side is IDLE.
- Throughput: 1 word/cycle with iready held high. 8 back-to-back subregions stream 64 words with no bubble, provided ibin_valid arrives at least every 8 cycles.
- Hold rule: while ovalid && !iready, odata, obin_idx, osub_idx and olast stay stable. ovalid never drops without a transfer, except on reset.
- Simultaneous release and capture: if a bank is freed by the bin-7 transfer in cycle N, obin_ready rises in cycle N+1. A capture in cycle N targets only the other bank, if it is free.
- Both banks FULL: obin_ready=0. An ibin_valid in that state is dropped and sets oerr_drop=1 until reset. Buffer contents are unaffected.
- olast is combinational from the registered sub and bin counters, gated by ovalid.
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro DESC_CLAMP_EN.
  - Defined: odata = min(bin value, CLAMP_MAX), an unsigned compare applied on the read path. Stored bank data is unmodified.
  - Not defined: odata = raw bin value, with no compare logic. CLAMP_MAX is unused.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then one capture with bins 1,2,...,8 and iready=1:
  - ovalid high for exactly 8 cycles starting 1 cycle after capture.
  - odata 1..8, obin_idx 0..7, osub_idx=0, olast=0.
- 16 captures, one every 8 cycles, iready=1:
  - 128 contiguous words.
  - olast high only on word 128 (osub_idx=15, obin_idx=7).
  - The next capture shows osub_idx=0.
- iready=0 after a capture, then 3 more ibin_valid pulses:
  - the first extra capture is accepted into bank 1 and obin_ready drops.
  - the next pulses set oerr_drop=1.
  - odata holds the bin-0 value throughout.
  - Raising iready drains 16 words, and obin_ready returns 1 cycle after the 8th transfer.
- iready toggling 1,0,1,0 during a subregion: every word transfers exactly once, in order, with stable data while stalled.
- ireset asserted after the 3rd word of subregion 5:
  - next cycle ovalid=0, obin_ready=1, oerr_drop=0.
  - the next capture is emitted with osub_idx=0, obin_idx=0.
- DESC_CLAMP_EN build, CLAMP_MAX=4095, bins 8191,4095,4096,0,...:
  - odata 4095,4095,4095,0.
  - without the macro, the same stimulus gives raw values.

Source files
------------

// File: rtl/descriptor_bin_serializer.sv
// Two-bank ping-pong capture of the 8 orientation bins of one subregion, streamed out
// as a bin/subregion-tagged descriptor word stream. Optional macro DESC_CLAMP_EN saturates words at CLAMP_MAX.
module descriptor_bin_serializer #(
  parameter int BIN_W      = 13,
  parameter int SUBREGIONS = 16
`ifdef DESC_CLAMP_EN
  ,
  parameter logic [BIN_W-1:0] CLAMP_MAX = BIN_W'(4095)
`endif
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic [BIN_W-1:0] ibin_value0,
  input  logic [BIN_W-1:0] ibin_value1,
  input  logic [BIN_W-1:0] ibin_value2,
  input  logic [BIN_W-1:0] ibin_value3,
  input  logic [BIN_W-1:0] ibin_value4,
  input  logic [BIN_W-1:0] ibin_value5,
  input  logic [BIN_W-1:0] ibin_value6,
  input  logic [BIN_W-1:0] ibin_value7,
  input  logic             ibin_valid,
  output logic             obin_ready,
  output logic [BIN_W-1:0] odata,
  output logic             ovalid,
  input  logic             iready,
  output logic [2:0]       obin_idx,
  output logic [3:0]       osub_idx,
  output logic             olast,
  output logic             oerr_drop
);

  localparam int         NBINS    = 8;
  localparam logic [2:0] BIN_LAST = 3'd7;
  localparam logic [3:0] SUB_LAST = 4'(SUBREGIONS - 1);

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_t;

  rd_state_t        rd_state, rd_state_nxt;
  logic [1:0]       bank_full, bank_full_nxt;
  logic             wbank, rbank;
  logic [2:0]       bin_cnt;
  logic [3:0]       sub_cnt;
  logic             err_drop;
  logic             cap, xfer, rel;
  logic [BIN_W-1:0] bin_in   [NBINS];
  logic [BIN_W-1:0] bank_mem [2][NBINS];
  logic [BIN_W-1:0] rd_word, rd_shaped;

  assign bin_in[0] = ibin_value0;
  assign bin_in[1] = ibin_value1;
  assign bin_in[2] = ibin_value2;
  assign bin_in[3] = ibin_value3;
  assign bin_in[4] = ibin_value4;
  assign bin_in[5] = ibin_value5;
  assign bin_in[6] = ibin_value6;
  assign bin_in[7] = ibin_value7;

  // Ready is a pure register decode so it never depends on the downstream iready.
  assign obin_ready = ~bank_full[wbank];
  assign cap        = ibin_valid & obin_ready;
  assign xfer       = (rd_state == RD_SEND) & iready;
  assign rel        = xfer & (bin_cnt == BIN_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bank_full_nxt = bank_full;
    if (cap) bank_full_nxt[wbank] = 1'b1;
    if (rel) bank_full_nxt[rbank] = 1'b0;
  end

  // Looking at next-cycle fullness lets a capture start streaming on the very next
  // cycle and lets a capture coincident with the bin-7 release continue without a bubble.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (bank_full_nxt[rbank]) rd_state_nxt = RD_SEND;
      RD_SEND: if (rel && !bank_full_nxt[~rbank]) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      rd_state  <= RD_IDLE;
      bank_full <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      bin_cnt   <= '0;
      sub_cnt   <= '0;
      err_drop  <= 1'b0;
    end else begin
      rd_state  <= rd_state_nxt;
      bank_full <= bank_full_nxt;
      if (cap) wbank <= ~wbank;
      if (ibin_valid && !obin_ready) err_drop <= 1'b1;
      if (xfer) begin
        if (bin_cnt == BIN_LAST) begin
          bin_cnt <= '0;
          rbank   <= ~rbank;
          sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 4'd1;
        end else begin
          bin_cnt <= bin_cnt + 3'd1;
        end
      end
    end
  end

  // NOTE: bank storage is not reset; the FULL flags alone decide whether its contents are used.
  always_ff @(posedge iclk) begin
    if (cap) begin
      for (int i = 0; i < NBINS; i++) bank_mem[wbank][i] <= bin_in[i];
    end
  end

  assign rd_word = bank_mem[rbank][bin_cnt];

`ifdef DESC_CLAMP_EN
  assign rd_shaped = (rd_word > CLAMP_MAX) ? CLAMP_MAX : rd_word;
`else
  assign rd_shaped = rd_word;
`endif

  assign ovalid    = (rd_state == RD_SEND);
  assign odata     = ovalid ? rd_shaped : '0;
  assign obin_idx  = bin_cnt;
  assign osub_idx  = sub_cnt;
  assign olast     = ovalid & (sub_cnt == SUB_LAST) & (bin_cnt == BIN_LAST);
  assign oerr_drop = err_drop;

endmodule

// File: tb/tb_descriptor_bin_serializer.sv
// Directed bench for descriptor_bin_serializer: a scoreboard queue is filled at capture
// time and drained by a monitor on every output transfer.
module tb_descriptor_bin_serializer;

  typedef logic [12:0] bins_t [8];

  typedef struct {
    logic [12:0] data;
    logic [2:0]  bin;
    logic [3:0]  sub;
    logic        last;
  } exp_t;

  logic        iclk = 1'b0;
  logic        ireset;
  logic [12:0] ibin_value0, ibin_value1, ibin_value2, ibin_value3;
  logic [12:0] ibin_value4, ibin_value5, ibin_value6, ibin_value7;
  logic        ibin_valid;
  logic        obin_ready;
  logic [12:0] odata;
  logic        ovalid;
  logic        iready;
  logic [2:0]  obin_idx;
  logic [3:0]  osub_idx;
  logic        olast;
  logic        oerr_drop;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   model_sub  = 0;
  int   words_seen = 0;
  int   bubbles    = 0;

  always #5 iclk = ~iclk;

  descriptor_bin_serializer dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .ibin_value0 (ibin_value0),
    .ibin_value1 (ibin_value1),
    .ibin_value2 (ibin_value2),
    .ibin_value3 (ibin_value3),
    .ibin_value4 (ibin_value4),
    .ibin_value5 (ibin_value5),
    .ibin_value6 (ibin_value6),
    .ibin_value7 (ibin_value7),
    .ibin_valid  (ibin_valid),
    .obin_ready  (obin_ready),
    .odata       (odata),
    .ovalid      (ovalid),
    .iready      (iready),
    .obin_idx    (obin_idx),
    .osub_idx    (osub_idx),
    .olast       (olast),
    .oerr_drop   (oerr_drop)
  );

  function automatic logic [12:0] shape(input logic [12:0] v);
`ifdef DESC_CLAMP_EN
    return (v > 13'd4095) ? 13'd4095 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Drives one ibin_valid pulse; an accepted capture queues its 8 expected words.
  task automatic capture(input bins_t v, input logic accept);
    exp_t e;
    ibin_value0 = v[0]; ibin_value1 = v[1]; ibin_value2 = v[2]; ibin_value3 = v[3];
    ibin_value4 = v[4]; ibin_value5 = v[5]; ibin_value6 = v[6]; ibin_value7 = v[7];
    ibin_valid  = 1'b1;
    check("obin_ready_at_capture", obin_ready, accept);
    if (accept) begin
      for (int b = 0; b < 8; b++) begin
        e.data = shape(v[b]);
        e.bin  = 3'(b);
        e.sub  = 4'(model_sub);
        e.last = (model_sub == 15) && (b == 7);
        sb_q.push_back(e);
      end
      model_sub = (model_sub + 1) % 16;
    end
    tick();
    ibin_valid = 1'b0;
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    sb_q.delete();
    model_sub = 0;
    tick();
    ireset = 1'b0;
  endtask

  task automatic stall_check(input string tag);
    if (ovalid && !iready && sb_q.size() > 0) begin
      check({tag, "_data"}, odata, sb_q[0].data);
      check({tag, "_bin"}, obin_idx, sb_q[0].bin);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge iclk);
      if (!ireset && ovalid && iready) begin
        words_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_word_ovalid", ovalid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("word_data", odata, e.data);
          check("word_bin", obin_idx, e.bin);
          check("word_sub", osub_idx, e.sub);
          check("word_last", olast, e.last);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bins_t v;
    fork
      monitor();
    join_none

    ireset = 1'b1; iready = 1'b0; ibin_valid = 1'b0;
    ibin_value0 = '0; ibin_value1 = '0; ibin_value2 = '0; ibin_value3 = '0;
    ibin_value4 = '0; ibin_value5 = '0; ibin_value6 = '0; ibin_value7 = '0;
    repeat (3) tick();
    ireset = 1'b0;

    check("rst_ovalid", ovalid, 1'b0);
    check("rst_odata", odata, 13'd0);
    check("rst_obin_idx", obin_idx, 3'd0);
    check("rst_osub_idx", osub_idx, 4'd0);
    check("rst_olast", olast, 1'b0);
    check("rst_oerr_drop", oerr_drop, 1'b0);
    check("rst_obin_ready", obin_ready, 1'b1);

    // Single subregion: ovalid for exactly 8 cycles right after the capture edge.
    iready = 1'b1;
    v = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7, 13'd8};
    capture(v, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t1_ovalid_window", ovalid, (i < 8));
      tick();
    end
    check("t1_drained", sb_q.size(), 0);

    // Full descriptor: 16 captures every 8 cycles give 128 contiguous words.
    do_reset();
    words_seen = 0;
    bubbles    = 0;
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 8; b++) v[b] = 13'(k * 8 + b + 100);
      capture(v, 1'b1);
      if (!ovalid) bubbles++;
      for (int j = 1; j < 8; j++) begin
        tick();
        if (!ovalid) bubbles++;
      end
    end
    check("t2_no_bubble", bubbles, 0);
    tick();
    check("t2_word_count", words_seen, 128);
    check("t2_idle_after", ovalid, 1'b0);
    check("t2_drained", sb_q.size(), 0);
    v = '{13'd11, 13'd12, 13'd13, 13'd14, 13'd15, 13'd16, 13'd17, 13'd18};
    capture(v, 1'b1);
    check("t2_sub_wrap", osub_idx, 4'd0);
    check("t2_bin_start", obin_idx, 3'd0);
    repeat (8) tick();
    check("t2_extra_drained", sb_q.size(), 0);

    // Stalled output: second capture fills bank 1, further pulses are dropped.
    iready = 1'b0;
    v = '{13'd201, 13'd202, 13'd203, 13'd204, 13'd205, 13'd206, 13'd207, 13'd208};
    capture(v, 1'b1);
    stall_check("t3_hold_a");
    check("t3_err_clear_a", oerr_drop, 1'b0);
    v = '{13'd301, 13'd302, 13'd303, 13'd304, 13'd305, 13'd306, 13'd307, 13'd308};
    capture(v, 1'b1);
    stall_check("t3_hold_b");
    check("t3_err_clear_b", oerr_drop, 1'b0);
    v = '{13'd401, 13'd402, 13'd403, 13'd404, 13'd405, 13'd406, 13'd407, 13'd408};
    capture(v, 1'b0);
    stall_check("t3_hold_c");
    check("t3_err_set", oerr_drop, 1'b1);
    capture(v, 1'b0);
    stall_check("t3_hold_d");
    check("t3_hold_ovalid", ovalid, 1'b1);
    iready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_ready_low_drain", obin_ready, 1'b0);
      tick();
    end
    check("t3_ready_back", obin_ready, 1'b1);
    repeat (8) tick();
    check("t3_idle_after", ovalid, 1'b0);
    check("t3_drained", sb_q.size(), 0);
    check("t3_err_sticky", oerr_drop, 1'b1);

    // Toggling iready: in-order single transfers and stable data while stalled.
    v = '{13'd501, 13'd502, 13'd503, 13'd504, 13'd505, 13'd506, 13'd507, 13'd508};
    capture(v, 1'b1);
    for (int i = 0; i < 20; i++) begin
      iready = (i % 2 == 0);
      stall_check("t4_stall");
      tick();
    end
    iready = 1'b1;
    check("t4_idle_after", ovalid, 1'b0);
    check("t4_drained", sb_q.size(), 0);

    // Mid-stream reset after the third word of subregion 5.
    v = '{13'd601, 13'd602, 13'd603, 13'd604, 13'd605, 13'd606, 13'd607, 13'd608};
    capture(v, 1'b1);
    repeat (8) tick();
    v = '{13'd701, 13'd702, 13'd703, 13'd704, 13'd705, 13'd706, 13'd707, 13'd708};
    capture(v, 1'b1);
    check("t5_sub5", osub_idx, 4'd5);
    repeat (3) tick();
    check("t5_bin3", obin_idx, 3'd3);
    ireset = 1'b1;
    sb_q.delete();
    model_sub = 0;
    tick();
    check("t5_rst_ovalid", ovalid, 1'b0);
    check("t5_rst_ready", obin_ready, 1'b1);
    check("t5_rst_err", oerr_drop, 1'b0);
    check("t5_rst_odata", odata, 13'd0);
    check("t5_rst_sub", osub_idx, 4'd0);
    ireset = 1'b0;
    v = '{13'd801, 13'd802, 13'd803, 13'd804, 13'd805, 13'd806, 13'd807, 13'd808};
    capture(v, 1'b1);
    check("t5_restart_ovalid", ovalid, 1'b1);
    check("t5_restart_sub", osub_idx, 4'd0);
    check("t5_restart_bin", obin_idx, 3'd0);
    repeat (8) tick();
    check("t5_drained", sb_q.size(), 0);

    // Saturation boundary values (raw values expected without the clamp build).
    v = '{13'd8191, 13'd4095, 13'd4096, 13'd0, 13'd1, 13'd4094, 13'd4097, 13'd100};
    capture(v, 1'b1);
    check("t6_first_word", odata, shape(13'd8191));
    repeat (8) tick();
    check("t6_drained", sb_q.size(), 0);
    check("t6_idle_after", ovalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
